// File: rtl/packet_assembler.sv
// Packet assembler: buffers a byte message (truncated to MAX_LEN) and emits it as
// an Avalon-ST packet of dest, len, payload and an XOR checksum.
module packet_assembler #(
    parameter int MAX_LEN = 64,
    parameter int DATA_W  = 8
) (
    input  logic              clock_clk,
    input  logic              reset_reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [7:0]        cfg_dest,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [15:0]       pkt_count,
    output logic [7:0]        trunc_count
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        DISCARD  = 3'd2,
        HDR_DEST = 3'd3,
        HDR_LEN  = 3'd4,
        PAYLOAD  = 3'd5,
        CKSUM    = 3'd6
    } state_t;

    function automatic logic [7:0] xor3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t            state_r, state_s;
    logic [7:0]        len_r, len_s;
    logic [7:0]        dest_r, dest_s;
    logic [7:0]        cksum_r, cksum_s;
    logic [7:0]        idx_r, idx_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic              trunc_inc_s;
    logic              pkt_inc_s;
    logic              accept_s;
    logic              xfer_s;
    logic [7:0]        out_data_s;
    logic [DATA_W-1:0] buffer [2**AW];

    // Next-state, buffer write and counter-event decode
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        dest_s      = dest_r;
        cksum_s     = cksum_r;
        idx_s       = idx_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = '0;
        trunc_inc_s = 1'b0;
        pkt_inc_s   = 1'b0;
        accept_s    = in_valid & in_ready;
        xfer_s      = out_valid & out_ready;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    dest_s  = cfg_dest;
                    len_s   = 8'd1;
                    cksum_s = in_data;
                    if (in_last) begin
                        state_s = HDR_DEST;
                    end else if (MAX_LEN == 1) begin
                        trunc_inc_s = 1'b1;
                        state_s     = HDR_DEST;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = len_r[AW-1:0];
                    len_s     = len_r + 8'd1;
                    cksum_s   = cksum_r ^ in_data;
                    if (in_last) begin
                        state_s = HDR_DEST;
                    end else if (len_r + 8'd1 == MAX_LEN_B) begin
                        trunc_inc_s = 1'b1;
                        state_s     = DISCARD;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            DISCARD: begin
                if (accept_s && in_last) begin
                    state_s = HDR_DEST;
                end else begin
                    state_s = DISCARD;
                end
            end
            HDR_DEST: begin
                if (xfer_s) begin
                    state_s = HDR_LEN;
                end else begin
                    state_s = HDR_DEST;
                end
            end
            HDR_LEN: begin
                if (xfer_s) begin
                    idx_s   = 8'd0;
                    state_s = PAYLOAD;
                end else begin
                    state_s = HDR_LEN;
                end
            end
            PAYLOAD: begin
                if (xfer_s) begin
                    idx_s = idx_r + 8'd1;
                    if (idx_r + 8'd1 == len_r) begin
                        state_s = CKSUM;
                    end else begin
                        state_s = PAYLOAD;
                    end
                end else begin
                    state_s = PAYLOAD;
                end
            end
            CKSUM: begin
                if (xfer_s) begin
                    pkt_inc_s = 1'b1;
                    len_s     = 8'd0;
                    state_s   = IDLE;
                end else begin
                    state_s = CKSUM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output beat for the upcoming state; registered so it holds steady under stall
    always_comb begin
        out_data_s = 8'h00;
        case (state_s)
            HDR_DEST: out_data_s = dest_s;
            HDR_LEN:  out_data_s = len_s;
            PAYLOAD:  out_data_s = buffer[idx_s[AW-1:0]];
            CKSUM:    out_data_s = xor3(dest_s, len_s, cksum_s);
            default:  out_data_s = 8'h00;
        endcase
    end

    // Payload storage; contents are meaningless once len is cleared
    always_ff @(posedge clock_clk) begin
        if (wr_en_s) begin
            buffer[wr_addr_s] <= in_data;
        end
    end

    // State, counters and registered handshake/output signals
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_r     <= IDLE;
            len_r       <= 8'd0;
            dest_r      <= 8'd0;
            cksum_r     <= 8'd0;
            idx_r       <= 8'd0;
            pkt_count   <= 16'd0;
            trunc_count <= 8'd0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_data    <= 8'd0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            dest_r      <= dest_s;
            cksum_r     <= cksum_s;
            idx_r       <= idx_s;
            pkt_count   <= pkt_inc_s ? pkt_count + 16'd1 : pkt_count;
            trunc_count <= trunc_inc_s ? sat_inc8(trunc_count) : trunc_count;
            in_ready    <= (state_s == IDLE) || (state_s == FILL) || (state_s == DISCARD);
            out_valid   <= (state_s == HDR_DEST) || (state_s == HDR_LEN) ||
                           (state_s == PAYLOAD) || (state_s == CKSUM);
            out_sop     <= (state_s == HDR_DEST);
            out_eop     <= (state_s == CKSUM);
            out_data    <= out_data_s;
        end
    end

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler (MAX_LEN=4): expected beats are queued
// when a message is driven and compared as the DUT emits them.
module tb_packet_assembler;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  cfg_dest;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] pkt_count;
    logic [7:0]  trunc_count;

    logic [9:0]  sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pkt = 16'd0;
    logic [7:0]  exp_trunc = 8'd0;
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [9:0]  prev_beat = 10'd0;

    always #5 clk = ~clk;

    packet_assembler #(.MAX_LEN(ML), .DATA_W(8)) dut (
        .clock_clk  (clk),
        .reset_reset(reset_reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .cfg_dest   (cfg_dest),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .pkt_count  (pkt_count),
        .trunc_count(trunc_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop, stall stability, upstream back-pressure
    always @(negedge clk) begin
        if (!reset_reset) begin
            if (stall_prev) begin
                check_val("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, prev_beat});
            end
            if (out_valid) begin
                check_val("in_ready_blocked", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_beat", sb_q.size(), 1);
                end else begin
                    check_val("beat", {out_sop, out_eop, out_data}, sb_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_beat  = {out_sop, out_eop, out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Downstream ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_pkt(input logic [7:0] dest, input logic [7:0] b [8], input int n);
        int L;
        logic [7:0] c;
        L = (n > ML) ? ML : n;
        c = dest ^ 8'(L);
        sb_q.push_back({2'b10, dest});
        sb_q.push_back({2'b00, 8'(L)});
        for (int k = 0; k < L; k++) begin
            sb_q.push_back({2'b00, b[k]});
            c = c ^ b[k];
        end
        sb_q.push_back({2'b01, c});
        exp_pkt = exp_pkt + 16'd1;
        if (n > ML && exp_trunc != 8'hFF) begin
            exp_trunc = exp_trunc + 8'd1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the last byte is accepted
    task automatic send_msg(input logic [7:0] dest, input logic [7:0] b [8], input int n);
        bit acc;
        push_pkt(dest, b, n);
        for (int k = 0; k < n; k++) begin
            cfg_dest = (k == 0) ? dest : ~dest;
            in_data  = b[k];
            in_last  = (k == n - 1);
            in_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 500 && !acc; t++) begin
                acc = in_ready;
                @(posedge clk);
                @(negedge clk);
            end
            if (!acc) begin
                check_val("accept_timeout", in_ready, 1);
            end
        end
        check_val("first_valid_latency", out_valid, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!(sb_q.size() == 0 && in_ready) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) begin
            check_val("done_timeout", sb_q.size(), 0);
        end
    endtask

    initial begin
        logic [7:0] b [8];
        int cyc;
        int n;
        reset_reset = 1'b1;
        in_data     = 8'd0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        cfg_dest    = 8'd0;
        for (int k = 0; k < 8; k++) b[k] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", {out_valid, out_sop, out_eop}, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_pkt_count", pkt_count, 0);
        check_val("rst_trunc_count", trunc_count, 0);
        reset_reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready, 1);

        // Three-byte message, full-rate output
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        send_msg(8'h5A, b, 3);
        wait_done(cyc);
        check_val("burst_cycles", cyc, 6);
        check_val("pkt_count_1", pkt_count, exp_pkt);

        // Single-byte message
        b[0] = 8'hFF;
        send_msg(8'h00, b, 1);
        wait_done(cyc);
        check_val("single_cycles", cyc, 4);

        // Six-byte message truncated to four
        for (int k = 0; k < 6; k++) b[k] = 8'(k + 1);
        send_msg(8'hC3, b, 6);
        wait_done(cyc);
        check_val("trunc_count_1", trunc_count, exp_trunc);
        check_val("pkt_count_3", pkt_count, exp_pkt);

        // Random lengths, back-to-back messages, random output stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(1, 7);
            for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
            send_msg(8'($urandom), b, n);
        end
        wait_done(cyc);
        rand_ready = 1'b0;
        @(negedge clk);
        check_val("rand_pkt_count", pkt_count, exp_pkt);
        check_val("rand_trunc_count", trunc_count, exp_trunc);

        // Reset while emitting payload
        for (int k = 0; k < 4; k++) b[k] = 8'(8'hA0 + k);
        send_msg(8'h77, b, 4);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_reset = 1'b1;
        sb_q.delete();
        exp_pkt = 16'd0;
        exp_trunc = 8'd0;
        @(negedge clk);
        check_val("midrst_out_valid", {out_valid, out_sop, out_eop}, 0);
        check_val("midrst_counts", {pkt_count, trunc_count}, 0);
        check_val("midrst_in_ready", in_ready, 0);
        reset_reset = 1'b0;
        @(negedge clk);
        check_val("midrst_post_in_ready", in_ready, 1);
        b[0] = 8'h5C; b[1] = 8'h3E;
        send_msg(8'h19, b, 2);
        wait_done(cyc);
        check_val("midrst_pkt_count", pkt_count, exp_pkt);

        // Packet counter wrap
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        @(negedge clk);
        check_val("preload_pkt_count", pkt_count, 16'hFFFF);
        exp_pkt = 16'hFFFF;
        b[0] = 8'h42;
        send_msg(8'h24, b, 1);
        wait_done(cyc);
        check_val("pkt_count_wrap", pkt_count, exp_pkt);

        // Truncation counter saturation
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 5; k++) b[k] = 8'($urandom);
            send_msg(8'(i), b, 5);
            wait_done(cyc);
            if (i == 254) begin
                check_val("trunc_count_255", trunc_count, exp_trunc);
            end
        end
        check_val("trunc_count_sat", trunc_count, exp_trunc);
        check_val("final_pkt_count", pkt_count, exp_pkt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
